// File: rtl/snp_req_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : snp_req_sched_if
//  Purpose  : Snoop request/response bus plus shared state-array port of the
//             snoop-request scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface snp_req_sched_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int SET_WIDTH    = 6,
    parameter int OFFSET_WIDTH = 6
);
    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;

    logic                    snp_req_valid;
    logic                    snp_req_ready;
    logic [ADDR_WIDTH-1:0]   snp_req_addr;
    logic [1:0]              snp_req_op;
    logic                    snp_rsp_valid;
    logic                    snp_rsp_ready;
    logic [1:0]              snp_rsp;
    logic [ADDR_WIDTH-1:0]   snp_rsp_addr;
    logic                    st_req;
    logic                    st_gnt;
    logic                    st_we;
    logic [SET_WIDTH-1:0]    st_set;
    logic [2:0]              st_wr_state;
    logic [TAG_WIDTH-1:0]    st_rd_tag;
    logic [2:0]              st_rd_state;

    // Scheduler side
    modport slave (
        input  snp_req_valid, snp_req_addr, snp_req_op, snp_rsp_ready,
               st_gnt, st_rd_tag, st_rd_state,
        output snp_req_ready, snp_rsp_valid, snp_rsp, snp_rsp_addr,
               st_req, st_we, st_set, st_wr_state
    );

    // Bus / arbiter / state-array side
    modport master (
        output snp_req_valid, snp_req_addr, snp_req_op, snp_rsp_ready,
               st_gnt, st_rd_tag, st_rd_state,
        input  snp_req_ready, snp_rsp_valid, snp_rsp, snp_rsp_addr,
               st_req, st_we, st_set, st_wr_state
    );
endinterface
`default_nettype wire

// File: rtl/snp_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : snp_req_sched (+ fsm_snp_req_ctrl)
//  Purpose  : Sequences one bus snoop through read / next-state / write-back
//             of the shared line-state array and returns the snoop response.
//             Optional macro SNP_MISS_WR_SKIP_EN skips the write on a miss.
//  Revision : 1.0  initial release
// ============================================================================
module snp_req_sched #(
    parameter int ADDR_WIDTH   = 32,
    parameter int SET_WIDTH    = 6,
    parameter int OFFSET_WIDTH = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    snp_req_sched_if.slave  bus
);
    localparam int         TAG_WIDTH  = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;
    localparam logic [1:0] SUT_INV    = 2'b01;
    localparam logic [2:0] ST_INVALID = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_RSP     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic                    snp_req_ready_q, snp_req_ready_d;
    logic                    snp_rsp_valid_q, snp_rsp_valid_d;
    logic [1:0]              snp_rsp_q, snp_rsp_d;
    logic [ADDR_WIDTH-1:0]   snp_rsp_addr_q, snp_rsp_addr_d;
    logic                    st_req_q, st_req_d;
    logic                    st_we_q, st_we_d;
    logic [SET_WIDTH-1:0]    st_set_q, st_set_d;
    logic [2:0]              st_wr_state_q, st_wr_state_d;

    logic                    w_hit;
    logic [2:0]              w_cur_st;
    logic [2:0]              w_fsm_nxt;
    logic [1:0]              w_fsm_rsp;

    // The captured address doubles as the response address for the whole snoop.
    assign w_hit    = (bus.st_rd_tag == snp_rsp_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]) &&
                      (bus.st_rd_state != ST_INVALID);
    assign w_cur_st = w_hit ? bus.st_rd_state : ST_INVALID;

    fsm_snp_req_ctrl u_ctrl (
        .op      (op_q),
        .cur_st  (w_cur_st),
        .nxt_st  (w_fsm_nxt),
        .snp_rsp (w_fsm_rsp)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        snp_rsp_d      = snp_rsp_q;
        snp_rsp_addr_d = snp_rsp_addr_q;
        st_set_d       = st_set_q;
        st_wr_state_d  = st_wr_state_q;

        case (state_q)
            S_IDLE: begin
                if (bus.snp_req_valid && snp_req_ready_q) begin
                    state_d        = S_RD_REQ;
                    op_d           = bus.snp_req_op;
                    snp_rsp_addr_d = bus.snp_req_addr;
                    st_set_d       = bus.snp_req_addr[OFFSET_WIDTH +: SET_WIDTH];
                end
            end
            S_RD_REQ: begin
                if (bus.st_gnt) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                snp_rsp_d     = w_hit ? w_fsm_rsp : SUT_INV;
                st_wr_state_d = w_hit ? w_fsm_nxt : bus.st_rd_state;
`ifdef SNP_MISS_WR_SKIP_EN
                state_d       = w_hit ? S_WR : S_RSP;
`else
                state_d       = S_WR;
`endif
            end
            S_WR: begin
                state_d = S_RSP;
            end
            S_RSP: begin
                if (bus.snp_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered images of the state being entered.
        snp_req_ready_d = (state_d == S_IDLE);
        snp_rsp_valid_d = (state_d == S_RSP);
        st_req_d        = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) || (state_d == S_WR);
        st_we_d         = (state_d == S_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= 2'b00;
            snp_req_ready_q <= 1'b0;
            snp_rsp_valid_q <= 1'b0;
            snp_rsp_q       <= SUT_INV;
            snp_rsp_addr_q  <= '0;
            st_req_q        <= 1'b0;
            st_we_q         <= 1'b0;
            st_set_q        <= '0;
            st_wr_state_q   <= ST_INVALID;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            snp_req_ready_q <= snp_req_ready_d;
            snp_rsp_valid_q <= snp_rsp_valid_d;
            snp_rsp_q       <= snp_rsp_d;
            snp_rsp_addr_q  <= snp_rsp_addr_d;
            st_req_q        <= st_req_d;
            st_we_q         <= st_we_d;
            st_set_q        <= st_set_d;
            st_wr_state_q   <= st_wr_state_d;
        end
    end

    assign bus.snp_req_ready = snp_req_ready_q;
    assign bus.snp_rsp_valid = snp_rsp_valid_q;
    assign bus.snp_rsp       = snp_rsp_q;
    assign bus.snp_rsp_addr  = snp_rsp_addr_q;
    assign bus.st_req        = st_req_q;
    assign bus.st_we         = st_we_q;
    assign bus.st_set        = st_set_q;
    assign bus.st_wr_state   = st_wr_state_q;
endmodule

// Per-line snoop transition and response decode. State bit0 marks a line that
// holds data the snoop may be served from.
module fsm_snp_req_ctrl (
    input  wire logic [1:0] op,
    input  wire logic [2:0] cur_st,
    output logic      [2:0] nxt_st,
    output logic      [1:0] snp_rsp
);
    localparam logic [1:0] SUR_RD     = 2'b00;
    localparam logic [1:0] SUR_INV    = 2'b01;
    localparam logic [1:0] SUR_RFO    = 2'b10;
    localparam logic [1:0] SUT_OKAY   = 2'b00;
    localparam logic [1:0] SUT_INV    = 2'b01;
    localparam logic [2:0] ST_INVALID = 3'b000;
    localparam logic [2:0] ST_SHARED  = 3'b001;

    always_comb begin
        nxt_st  = cur_st;
        snp_rsp = SUT_INV;
        case (op)
            SUR_RD: begin
                if (cur_st[0]) begin
                    nxt_st  = ST_SHARED;
                    snp_rsp = SUT_OKAY;
                end
            end
            SUR_INV: begin
                nxt_st  = ST_INVALID;
                snp_rsp = SUT_INV;
            end
            SUR_RFO: begin
                nxt_st  = ST_INVALID;
                snp_rsp = cur_st[0] ? SUT_OKAY : SUT_INV;
            end
            default: begin
                nxt_st  = cur_st;
                snp_rsp = SUT_INV;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_snp_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snp_req_sched
//  Purpose  : Directed self-checking bench for snp_req_sched with a
//             timeline-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snp_req_sched;
    localparam int AW = 32;
    localparam int SW = 6;
    localparam int OW = 6;
    localparam int TW = AW - SW - OW;

    localparam logic [1:0] SUR_RD    = 2'b00;
    localparam logic [1:0] SUR_INV   = 2'b01;
    localparam logic [1:0] SUR_RFO   = 2'b10;
    localparam logic [1:0] SUT_OKAY  = 2'b00;
    localparam logic [1:0] SUT_INV   = 2'b01;
    localparam logic [2:0] INVALID   = 3'b000;
    localparam logic [2:0] SHARED    = 3'b001;
    localparam logic [2:0] EXCLUSIVE = 3'b011;
    localparam logic [2:0] MODIFIED  = 3'b111;

`ifdef SNP_MISS_WR_SKIP_EN
    localparam int MISS_WE = -1;
    localparam int MISS_RV = 3;
`else
    localparam int MISS_WE = 3;
    localparam int MISS_RV = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snp_req_sched_if #(.ADDR_WIDTH(AW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW)) bus ();

    snp_req_sched #(.ADDR_WIDTH(AW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Snoop outcome from the line-state rules: {state to write, response}.
    function automatic logic [4:0] model_snoop(input logic [1:0] op, input logic hit,
                                               input logic [2:0] st);
        if (!hit) return {st, SUT_INV};
        case (op)
            SUR_RD:  return st[0] ? {SHARED, SUT_OKAY} : {st, SUT_INV};
            SUR_INV: return {INVALID, SUT_INV};
            SUR_RFO: return {INVALID, (st[0] ? SUT_OKAY : SUT_INV)};
            default: return {st, SUT_INV};
        endcase
    endfunction

    // Timeline of the active snoop, relative to the accept cycle t0.
    bit             active = 1'b0;
    int             t0, g, t_we, t_rv, t_end;
    logic [SW-1:0]  e_set;
    logic [AW-1:0]  e_addr;
    logic [2:0]     e_wr;
    logic [1:0]     e_rsp;

    always @(negedge clk) begin
        int r;
        if (active) begin
            r = cyc - t0;
            chk("req_ready", 32'(!(r >= 1 && r <= t_end)), 32'(bus.snp_req_ready));
            chk("st_req",    32'(bus.st_req),        32'((r >= 1 && r <= g + 1) || r == t_we));
            chk("st_we",     32'(bus.st_we),         32'(r == t_we));
            chk("rsp_valid", 32'(bus.snp_rsp_valid), 32'(r >= t_rv && r <= t_end));
            if (r >= 1 && r <= g + 1) chk("st_set", 32'(bus.st_set), 32'(e_set));
            if (r == t_we) chk("st_wr_state", 32'(bus.st_wr_state), 32'(e_wr));
            if (r >= t_rv && r <= t_end) begin
                chk("snp_rsp",      32'(bus.snp_rsp),      32'(e_rsp));
                chk("snp_rsp_addr", 32'(bus.snp_rsp_addr), 32'(e_addr));
            end
        end
    end

    task automatic run(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [TW-1:0] rtag, input logic [2:0] rstate,
                       input int gd, input int rd, input bit pend,
                       input logic [AW-1:0] naddr, input logic [1:0] nop,
                       input int lit_we, input logic [2:0] lit_wr,
                       input int lit_rv, input logic [1:0] lit_rsp);
        logic       hit;
        logic [4:0] m;
        bit         skip;
        hit  = (rtag == addr[AW-1 -: TW]) && (rstate != INVALID);
        m    = model_snoop(op, hit, rstate);
        skip = 1'b0;
`ifdef SNP_MISS_WR_SKIP_EN
        skip = !hit;
`endif
        g      = gd + 1;
        t_we   = skip ? -100 : g + 2;
        t_rv   = skip ? g + 2 : g + 3;
        t_end  = t_rv + rd;
        e_set  = addr[OW +: SW];
        e_addr = addr;
        e_wr   = m[4:2];
        e_rsp  = m[1:0];
        t0     = cyc;
        active = 1'b1;
        for (int r = 0; r <= t_end; r++) begin
            if (r == 0) begin
                bus.snp_req_valid = 1'b1;
                bus.snp_req_addr  = addr;
                bus.snp_req_op    = op;
            end else if (pend && r >= t_rv) begin
                bus.snp_req_valid = 1'b1;
                bus.snp_req_addr  = naddr;
                bus.snp_req_op    = nop;
            end else begin
                bus.snp_req_valid = 1'b0;
                bus.snp_req_addr  = $urandom;
                bus.snp_req_op    = 2'($urandom_range(0, 2));
            end
            bus.st_gnt = (r >= g && r <= g + 2);
            if (r == g + 1) begin
                bus.st_rd_tag   = rtag;
                bus.st_rd_state = rstate;
            end else begin
                bus.st_rd_tag   = TW'($urandom);
                bus.st_rd_state = 3'($urandom);
            end
            bus.snp_rsp_ready = (r == t_end);
            if (r == lit_we) begin
                chk("lit_st_we",       32'(bus.st_we),       32'(1));
                chk("lit_st_wr_state", 32'(bus.st_wr_state), 32'(lit_wr));
            end
            if (r == lit_rv - 1) chk("lit_rsp_valid_early", 32'(bus.snp_rsp_valid), 32'(0));
            if (r == lit_rv) begin
                chk("lit_rsp_valid", 32'(bus.snp_rsp_valid), 32'(1));
                chk("lit_snp_rsp",   32'(bus.snp_rsp),       32'(lit_rsp));
            end
            @(posedge clk); #1;
        end
        if (!pend) bus.snp_req_valid = 1'b0;
        bus.snp_rsp_ready = 1'b0;
        bus.st_gnt        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.snp_req_valid = 1'b0;
        bus.snp_req_addr  = '0;
        bus.snp_req_op    = SUR_RD;
        bus.snp_rsp_ready = 1'b0;
        bus.st_gnt        = 1'b0;
        bus.st_rd_tag     = '0;
        bus.st_rd_state   = INVALID;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",   32'(bus.snp_req_ready), 32'(0));
        chk("rst_rsp_valid",   32'(bus.snp_rsp_valid), 32'(0));
        chk("rst_snp_rsp",     32'(bus.snp_rsp),       32'(SUT_INV));
        chk("rst_rsp_addr",    32'(bus.snp_rsp_addr),  32'(0));
        chk("rst_st_req",      32'(bus.st_req),        32'(0));
        chk("rst_st_we",       32'(bus.st_we),         32'(0));
        chk("rst_st_set",      32'(bus.st_set),        32'(0));
        chk("rst_st_wr_state", 32'(bus.st_wr_state),   32'(INVALID));
        rst = 1'b0;
        @(posedge clk); #1;

        // Hit, read on a data-holding line
        run(SUR_RD, {20'hABCDE, 6'd5, 6'd3}, 20'hABCDE, EXCLUSIVE, 0, 0, 1'b0, '0, SUR_RD,
            3, SHARED, 4, SUT_OKAY);
        // Hit, invalidate
        run(SUR_INV, {20'h12345, 6'd63, 6'd0}, 20'h12345, MODIFIED, 0, 1, 1'b0, '0, SUR_RD,
            3, INVALID, 4, SUT_INV);
        // RFO with grant held off for 3 cycles
        run(SUR_RFO, {20'h0F0F0, 6'd0, 6'd17}, 20'h0F0F0, SHARED, 3, 0, 1'b0, '0, SUR_RD,
            6, INVALID, 7, SUT_OKAY);
        // Miss by tag mismatch
        run(SUR_RD, {20'h55555, 6'd9, 6'd0}, 20'h55554, EXCLUSIVE, 0, 0, 1'b0, '0, SUR_RD,
            MISS_WE, EXCLUSIVE, MISS_RV, SUT_INV);
        // Miss by INVALID line state with matching tag
        run(SUR_INV, {20'hFFFFF, 6'd33, 6'd1}, 20'hFFFFF, INVALID, 1, 0, 1'b0, '0, SUR_RD,
            -1, INVALID, MISS_RV + 1, SUT_INV);
        // Response stalled 5 cycles with the next request already pending
        run(SUR_RD, {20'h00042, 6'd17, 6'd2}, 20'h00042, MODIFIED, 1, 5, 1'b1,
            {20'h00077, 6'd2, 6'd9}, SUR_RFO, 4, SHARED, 5, SUT_OKAY);
        run(SUR_RFO, {20'h00077, 6'd2, 6'd9}, 20'h00077, EXCLUSIVE, 0, 0, 1'b0, '0, SUR_RD,
            3, INVALID, 4, SUT_OKAY);

        // Reset asserted while in the write-back cycle
        active = 1'b0;
        bus.snp_req_valid = 1'b1;
        bus.snp_req_addr  = {20'h3C3C3, 6'd7, 6'd0};
        bus.snp_req_op    = SUR_RD;
        bus.st_gnt        = 1'b1;
        @(posedge clk); #1;
        bus.snp_req_valid = 1'b0;
        @(posedge clk); #1;
        bus.st_rd_tag     = 20'h3C3C3;
        bus.st_rd_state   = EXCLUSIVE;
        @(posedge clk); #1;
        chk("wr_before_reset", 32'(bus.st_we), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_st_we",     32'(bus.st_we),         32'(0));
        chk("midrst_st_req",    32'(bus.st_req),        32'(0));
        chk("midrst_rsp_valid", 32'(bus.snp_rsp_valid), 32'(0));
        chk("midrst_req_ready", 32'(bus.snp_req_ready), 32'(0));
        bus.st_gnt = 1'b0;
        @(posedge clk); #1;
        chk("rsthold_rsp_valid", 32'(bus.snp_rsp_valid), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_req_ready", 32'(bus.snp_req_ready), 32'(1));
        chk("postrst_st_we",     32'(bus.st_we),         32'(0));

        run(SUR_RD, {20'h3C3C3, 6'd7, 6'd0}, 20'h3C3C3, SHARED, 0, 2, 1'b0, '0, SUR_RD,
            3, SHARED, 4, SUT_OKAY);

        active = 1'b0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
